epl_write_demux_sub: RTL and testbench
======================================

EPL_WRITE_DEMUX_SUB -- requirements
Module: epl_write_demux_sub

Interface
REQ-001 Parameter: SETUP_CYC, default 1, cycles data is driven before the enable pulse (range 1..15).
REQ-002 Parameter: WPULSE_CYC, default 4, width of the write-enable pulse in cycles (range 1..15).
REQ-003 Clocking SHALL be: one clock, pClk_i; reset nRst_i is asynchronous and active-low.
REQ-004 pClk_i  in  1  clock, rising edge.
REQ-005 nRst_i  in  1  async active-low reset.
REQ-006 pWrite01_i  in  1  write request, sampled each edge.
REQ-007 pDi_i  in  `TWORD_WIDTH (7)  word to write.
REQ-008 pAcy2_i  in  `ADDR_AYO (2)  one-hot column-group select: 01 = even columns, 10 = odd columns.
REQ-009 pDto_i  in  `COLUMN (14)  column read-back data, used only for verify.
REQ-010 pDti_o  out  `COLUMN  column write data.
REQ-011 pCwe_o  out  `COLUMN  per-column write enable.
REQ-012 pWbusy_o  out  1  high while a write is in progress.
REQ-013 pWrite1_o  out  1  one-cycle completion pulse.
REQ-014 pWerr_o  out  1  error flag, valid only while pWrite1_o is high.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, VERIFY and DONE, driven by one 4-bit down-counter.
REQ-016 In IDLE, when pWrite01_i=1 and pAcy2_i is valid, the block SHALL latch pDi_i and pAcy2_i and go to SETUP; pWbusy_o is high from the next cycle.
REQ-017 Scatter mapping SHALL be: for select 01, bit i of the word goes to column 2i; for select 10, bit i goes to column 2i+1; unselected columns are driven 0.
REQ-018 SETUP SHALL last SETUP_CYC cycles, with pDti_o driven and pCwe_o=0.
REQ-019 PULSE SHALL last WPULSE_CYC cycles, with pCwe_o=1 on the 7 selected columns only.
REQ-020 HOLD SHALL last 1 cycle, with pCwe_o=0 and pDti_o held.
REQ-021 HOLD SHALL go to VERIFY when `EPL_WR_VERIFY_EN is defined, and to DONE otherwise.
REQ-022 DONE SHALL last 1 cycle, with pWrite1_o=1, pWbusy_o=0 and pDti_o=0, then return to IDLE.
REQ-023 pWrite01_i SHALL be ignored outside IDLE; no request is queued.
REQ-024 A new request SHALL be accepted in the cycle after DONE at the earliest.
REQ-025 Invalid select (00 or 11) with pWrite01_i=1 in IDLE: no FSM entry and no enables; the next cycle gives pWrite1_o=1 and pWerr_o=1.
REQ-026 Changes on pDi_i or pAcy2_i after acceptance SHALL NOT affect the write in progress.
REQ-027 pCwe_o SHALL come directly from flops (glitch-free); all outputs are registered.

Reset
REQ-028 Asserting nRst_i SHALL immediately force IDLE and set pDti_o, pCwe_o, pWbusy_o, pWrite1_o and pWerr_o to 0, latched data to 0 and the counter to 0.
REQ-029 Reset during PULSE SHALL drop pCwe_o asynchronously; the write is abandoned and no pWrite1_o is issued.
REQ-030 After nRst_i deasserts, the first request SHALL be accepted at the next rising edge.

Configuration
REQ-031 With `EPL_WR_VERIFY_EN defined: VERIFY lasts 1 cycle and gathers the 7 selected columns of pDto_i using the same mapping as REQ-017.
REQ-032 With `EPL_WR_VERIFY_EN defined: pWerr_o in DONE is 1 if the gathered bits differ from the latched word, else 0.
REQ-033 Without the macro: the VERIFY state is unreachable, pDto_i is unused, and pWerr_o is 1 only for REQ-025.

Structure
REQ-034 `COLUMN, `TWORD_WIDTH, `ADDR_AYO and the FSM state encodings SHALL live in EPLFFRAM02_spec.vh.
REQ-035 Sub-module epl_col_scatter (combinational, word + select -> 14-bit column vector) SHALL be instantiated once for pDti_o.
REQ-036 pCwe_o SHALL be built by epl_col_scatter with an all-ones word.

Verification
REQ-037 Defaults, no macro: pDi_i=7'h55, pAcy2_i=01, request accepted at edge 0 -> SETUP cycle 1; pCwe_o=14'h1555 cycles 2-5; HOLD cycle 6; pWrite1_o=1, pWerr_o=0 in cycle 7.
REQ-038 pDi_i=7'h7F, pAcy2_i=10 -> pDti_o=14'h2AAA and pCwe_o=14'h2AAA during PULSE.
REQ-039 pAcy2_i=11 with request -> pCwe_o stays 0; pWrite1_o=1 and pWerr_o=1 one cycle later.
REQ-040 Request pulsed again during PULSE, with pDi_i changed -> ignored; exactly one pWrite1_o, using the original data.
REQ-041 nRst_i low at cycle 3 of PULSE -> pCwe_o=0 immediately; no pWrite1_o; a new request after release completes normally.
REQ-042 With `EPL_WR_VERIFY_EN: pDto_i matches -> pWerr_o=0 in cycle 8; pDto_i[4] flipped for word 7'h55 on even columns -> pWerr_o=1.

Source files
------------

// File: rtl/epl_write_demux_sub_pkg.sv
// Shared widths, select codes, FSM encoding and the column gather helper
// for the EPL write demultiplexer.
package epl_write_demux_sub_pkg;

  localparam int COLUMN      = 14;
  localparam int TWORD_WIDTH = 7;
  localparam int ADDR_AYO    = 2;

  localparam logic [ADDR_AYO-1:0] SEL_EVEN = 2'b01;
  localparam logic [ADDR_AYO-1:0] SEL_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5
  } wr_state_e;

  function automatic logic sel_valid(input logic [ADDR_AYO-1:0] sel);
    return (sel == SEL_EVEN) || (sel == SEL_ODD);
  endfunction

  // Inverse of the column scatter: pick the word bits back out of a column vector.
  function automatic logic [TWORD_WIDTH-1:0] col_gather(input logic [COLUMN-1:0]   col,
                                                        input logic [ADDR_AYO-1:0] sel);
    logic [TWORD_WIDTH-1:0] word;
    word = '0;
    case (sel)
      SEL_EVEN: for (int i = 0; i < TWORD_WIDTH; i++) word[i] = col[2*i];
      SEL_ODD:  for (int i = 0; i < TWORD_WIDTH; i++) word[i] = col[2*i+1];
      default:  word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/epl_write_demux_sub_col_scatter.sv
// epl_col_scatter: spreads a 7-bit word onto the even or odd columns of the
// 14-column array; unselected columns and invalid selects give zero.
module epl_col_scatter
  import epl_write_demux_sub_pkg::*;
(
  input  logic [TWORD_WIDTH-1:0] i_word,
  input  logic [ADDR_AYO-1:0]    i_sel,
  output logic [COLUMN-1:0]      o_col
);

  // Bit i lands on column 2i (even group) or 2i+1 (odd group).
  always_comb begin
    o_col = '0;
    case (i_sel)
      SEL_EVEN: for (int i = 0; i < TWORD_WIDTH; i++) o_col[2*i]   = i_word[i];
      SEL_ODD:  for (int i = 0; i < TWORD_WIDTH; i++) o_col[2*i+1] = i_word[i];
      default:  o_col = '0;
    endcase
  end

endmodule

// File: rtl/epl_write_demux_sub.sv
// EPL write demultiplexer: sequences setup / enable pulse / hold for one word
// onto a column group. Optional read-back check enabled by EPL_WR_VERIFY_EN.
module epl_write_demux_sub
  import epl_write_demux_sub_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned WPULSE_CYC = 4
) (
  input  logic                   pClk_i,
  input  logic                   nRst_i,
  input  logic                   pWrite01_i,
  input  logic [TWORD_WIDTH-1:0] pDi_i,
  input  logic [ADDR_AYO-1:0]    pAcy2_i,
  input  logic [COLUMN-1:0]      pDto_i,
  output logic [COLUMN-1:0]      pDti_o,
  output logic [COLUMN-1:0]      pCwe_o,
  output logic                   pWbusy_o,
  output logic                   pWrite1_o,
  output logic                   pWerr_o
);

  localparam logic [3:0] LP_SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LP_PULSE_LD  = 4'(WPULSE_CYC - 1);
  localparam logic [6:0] LP_ALL_ONES  = 7'h7F;

  wr_state_e              r_state;
  wr_state_e              w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic [TWORD_WIDTH-1:0] r_word;
  logic [ADDR_AYO-1:0]    r_sel;
  logic [TWORD_WIDTH-1:0] w_word_src;
  logic [ADDR_AYO-1:0]    w_sel_src;
  logic [COLUMN-1:0]      w_col_data;
  logic [COLUMN-1:0]      w_col_en;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_drive_nxt;
  logic                   w_verr;
  logic [COLUMN-1:0]      w_dti_nxt;
  logic [COLUMN-1:0]      w_cwe_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;

  // In IDLE the outputs for the first SETUP cycle come straight from the request.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_word_src = pDi_i;
      w_sel_src  = pAcy2_i;
    end else begin
      w_word_src = r_word;
      w_sel_src  = r_sel;
    end
  end

  epl_col_scatter u_scatter_data (
    .i_word (w_word_src),
    .i_sel  (w_sel_src),
    .o_col  (w_col_data)
  );

  epl_col_scatter u_scatter_en (
    .i_word (LP_ALL_ONES),
    .i_sel  (w_sel_src),
    .o_col  (w_col_en)
  );

`ifdef EPL_WR_VERIFY_EN
  // Read-back mismatch, meaningful only while in VERIFY.
  always_comb begin
    w_verr = (col_gather(pDto_i, r_sel) != r_word);
  end
`else
  logic w_unused_dto;
  assign w_unused_dto = ^pDto_i;
  assign w_verr       = 1'b0;
`endif

  // Next-state and down-counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pWrite01_i) begin
          if (sel_valid(pAcy2_i)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = LP_SETUP_LD;
          end else begin
            w_reject    = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = LP_PULSE_LD;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
`ifdef EPL_WR_VERIFY_EN
        w_state_nxt = ST_VERIFY;
`else
        w_state_nxt = ST_DONE;
`endif
      end
      ST_VERIFY: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output values for the cycle about to start, so every output is a flop.
  always_comb begin
    w_drive_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
                  (w_state_nxt == ST_HOLD)  || (w_state_nxt == ST_VERIFY);
    w_dti_nxt   = w_drive_nxt ? w_col_data : '0;
    w_cwe_nxt   = (w_state_nxt == ST_PULSE) ? w_col_en : '0;
    w_done_nxt  = (w_state_nxt == ST_DONE) || w_reject;
    w_err_nxt   = w_reject || ((r_state == ST_VERIFY) && w_verr);
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge pClk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_word    <= '0;
      r_sel     <= '0;
      pDti_o    <= '0;
      pCwe_o    <= '0;
      pWbusy_o  <= 1'b0;
      pWrite1_o <= 1'b0;
      pWerr_o   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_word  <= pDi_i;
        r_sel   <= pAcy2_i;
      end else begin
        r_word  <= r_word;
        r_sel   <= r_sel;
      end
      pDti_o    <= w_dti_nxt;
      pCwe_o    <= w_cwe_nxt;
      pWbusy_o  <= w_drive_nxt;
      pWrite1_o <= w_done_nxt;
      pWerr_o   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_epl_write_demux_sub.sv
// Bench for epl_write_demux_sub: directed vector table, reset-in-pulse
// sequence and randomized traffic against a cycle-offset reference model.
module tb_epl_write_demux_sub;

  localparam int S = 1;
  localparam int W = 4;
`ifdef EPL_WR_VERIFY_EN
  localparam int D = S + W + 3;
`else
  localparam int D = S + W + 2;
`endif

  logic        pClk_i = 1'b0;
  logic        nRst_i;
  logic        pWrite01_i;
  logic [6:0]  pDi_i;
  logic [1:0]  pAcy2_i;
  logic [13:0] pDto_i;
  logic [13:0] pDti_o;
  logic [13:0] pCwe_o;
  logic        pWbusy_o;
  logic        pWrite1_o;
  logic        pWerr_o;

  int n_cmp = 0;
  int n_bad = 0;

  epl_write_demux_sub dut (
    .pClk_i     (pClk_i),
    .nRst_i     (nRst_i),
    .pWrite01_i (pWrite01_i),
    .pDi_i      (pDi_i),
    .pAcy2_i    (pAcy2_i),
    .pDto_i     (pDto_i),
    .pDti_o     (pDti_o),
    .pCwe_o     (pCwe_o),
    .pWbusy_o   (pWbusy_o),
    .pWrite1_o  (pWrite1_o),
    .pWerr_o    (pWerr_o)
  );

  always #5 pClk_i = ~pClk_i;

  typedef struct {
    logic        req;
    logic [6:0]  di;
    logic [1:0]  sel;
    logic [13:0] dto;
    logic [13:0] e_dti;
    logic [13:0] e_cwe;
    logic        e_busy;
    logic        e_w1;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] scat(input logic [6:0] w, input logic [1:0] s);
    logic [13:0] c;
    c = 14'h0000;
    if (s == 2'b01 || s == 2'b10)
      for (int i = 0; i < 7; i++) c[2*i + ((s == 2'b10) ? 1 : 0)] = w[i];
    return c;
  endfunction

  task automatic add(input logic req, input logic [6:0] di, input logic [1:0] sel,
                     input logic [13:0] dto, input logic [13:0] e_dti, input logic [13:0] e_cwe,
                     input logic e_busy, input logic e_w1, input logic e_err);
    vec_t v;
    v.req = req; v.di = di; v.sel = sel; v.dto = dto;
    v.e_dti = e_dti; v.e_cwe = e_cwe; v.e_busy = e_busy; v.e_w1 = e_w1; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [13:0] dti, input logic [13:0] cwe,
                         input logic busy, input logic w1, input logic err);
    check({tag, ".dti"},   32'(pDti_o),    32'(dti));
    check({tag, ".cwe"},   32'(pCwe_o),    32'(cwe));
    check({tag, ".busy"},  32'(pWbusy_o),  32'(busy));
    check({tag, ".write1"},32'(pWrite1_o), 32'(w1));
    check({tag, ".werr"},  32'(pWerr_o),   32'(err));
  endtask

  // Reference model: position of the current cycle within an accepted write.
  bit         m_act;
  int         m_off;
  logic [6:0] m_word;
  logic [1:0] m_sel;
  bit         m_errp;
  bit         m_vbad;

  task automatic model_step();
    bit errn;
    errn = 1'b0;
    if (m_act) begin
      if (m_off == D - 1 && D == S + W + 3)
        m_vbad = (scat(m_word, m_sel) != (pDto_i & scat(7'h7F, m_sel)));
      if (m_off == D) m_act = 1'b0;
      else            m_off++;
    end else if (pWrite01_i) begin
      if (pAcy2_i == 2'b01 || pAcy2_i == 2'b10) begin
        m_act = 1'b1; m_off = 1; m_word = pDi_i; m_sel = pAcy2_i; m_vbad = 1'b0;
      end else begin
        errn = 1'b1;
      end
    end
    m_errp = errn;
  endtask

  task automatic model_check();
    logic [13:0] dti, cwe;
    logic busy, w1, err;
    dti = 14'h0; cwe = 14'h0; busy = 1'b0; w1 = m_errp; err = m_errp;
    if (m_act) begin
      if (m_off == D) begin
        w1 = 1'b1; err = m_vbad;
      end else begin
        dti  = scat(m_word, m_sel);
        busy = 1'b1;
        if (m_off > S && m_off <= S + W) cwe = scat(7'h7F, m_sel);
      end
    end
    chk_out("rand", dti, cwe, busy, w1, err);
  endtask

  initial begin
    int w1_cnt;
    int pulse_cnt;
    bit seen;
    logic [13:0] msk;

    nRst_i = 1'b0; pWrite01_i = 1'b0; pDi_i = 7'h00; pAcy2_i = 2'b00; pDto_i = 14'h0;
    repeat (2) @(negedge pClk_i);
    chk_out("reset", 14'h0, 14'h0, 1'b0, 1'b0, 1'b0);

    // Write 7'h55 to even columns; inputs wander after acceptance.
    add(1'b1, 7'h55, 2'b01, 14'h0, 14'h1111, 14'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h2A, 2'b10, 14'h0, 14'h1111, 14'h1555, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h2A, 2'b10, 14'h0, 14'h1111, 14'h1555, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h00, 2'b11, 14'h0, 14'h1111, 14'h1555, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h00, 2'b11, 14'h0, 14'h1111, 14'h1555, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h00, 2'b00, 14'h0, 14'h1111, 14'h0000, 1'b1, 1'b0, 1'b0);
`ifdef EPL_WR_VERIFY_EN
    add(1'b0, 7'h00, 2'b00, 14'h0,    14'h1111, 14'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h00, 2'b00, 14'h1111, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0);
`else
    add(1'b0, 7'h00, 2'b00, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0);
`endif
    // Request during DONE is not accepted.
    add(1'b1, 7'h7F, 2'b10, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 7'h7F, 2'b11, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b1);
    add(1'b1, 7'h7F, 2'b00, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b1);
    // Write 7'h7F to odd columns; repeated requests during the write are ignored.
    add(1'b1, 7'h7F, 2'b10, 14'h0, 14'h2AAA, 14'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 7'h00, 2'b01, 14'h0, 14'h2AAA, 14'h2AAA, 1'b1, 1'b0, 1'b0);
    add(1'b1, 7'h00, 2'b01, 14'h0, 14'h2AAA, 14'h2AAA, 1'b1, 1'b0, 1'b0);
    add(1'b1, 7'h01, 2'b01, 14'h0, 14'h2AAA, 14'h2AAA, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h01, 2'b01, 14'h0, 14'h2AAA, 14'h2AAA, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h01, 2'b01, 14'h0, 14'h2AAA, 14'h0000, 1'b1, 1'b0, 1'b0);
`ifdef EPL_WR_VERIFY_EN
    add(1'b0, 7'h00, 2'b00, 14'h0,    14'h2AAA, 14'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 7'h00, 2'b00, 14'h2AA8, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b1);
`else
    add(1'b0, 7'h00, 2'b00, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0);
`endif
    add(1'b0, 7'h00, 2'b00, 14'h0, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0);

    nRst_i = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      pWrite01_i = tbl[k].req; pDi_i = tbl[k].di; pAcy2_i = tbl[k].sel; pDto_i = tbl[k].dto;
      @(negedge pClk_i);
      chk_out($sformatf("vec%0d", k), tbl[k].e_dti, tbl[k].e_cwe, tbl[k].e_busy,
              tbl[k].e_w1, tbl[k].e_err);
    end

    // Reset in the third PULSE cycle abandons the write.
    pWrite01_i = 1'b1; pDi_i = 7'h55; pAcy2_i = 2'b01; pDto_i = 14'h1111;
    @(negedge pClk_i);
    pWrite01_i = 1'b0;
    repeat (3) @(negedge pClk_i);
    check("rst_pre.cwe", 32'(pCwe_o), 32'(14'h1555));
    #1 nRst_i = 1'b0;
    #1;
    check("rst_async.cwe",  32'(pCwe_o),   32'(14'h0));
    check("rst_async.dti",  32'(pDti_o),   32'(14'h0));
    check("rst_async.busy", 32'(pWbusy_o), 32'(1'b0));
    w1_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pClk_i);
      if (c == 1) nRst_i = 1'b1;
      if (pWrite1_o) w1_cnt++;
    end
    check("rst_no_write1", 32'(w1_cnt), 32'd0);

    pWrite01_i = 1'b1; pDi_i = 7'h33; pAcy2_i = 2'b10; pDto_i = scat(7'h33, 2'b10);
    seen = 1'b0; pulse_cnt = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge pClk_i);
      pWrite01_i = 1'b0;
      if (pCwe_o == 14'h2AAA) pulse_cnt++;
      if (pWrite1_o) begin
        seen = 1'b1;
        check("post_rst.werr", 32'(pWerr_o), 32'd0);
      end
    end
    check("post_rst.done_seen", 32'(seen), 32'd1);
    check("post_rst.pulse_len", 32'(pulse_cnt), 32'(W));
    @(negedge pClk_i);

    // Randomized traffic against the offset model.
    m_act = 1'b0; m_off = 0; m_errp = 1'b0; m_vbad = 1'b0; m_word = 7'h0; m_sel = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      pWrite01_i = ($urandom_range(0, 2) == 0);
      pDi_i      = 7'($urandom);
      case ($urandom_range(0, 7))
        0:       pAcy2_i = 2'b00;
        1:       pAcy2_i = 2'b11;
        2, 3, 4: pAcy2_i = 2'b01;
        default: pAcy2_i = 2'b10;
      endcase
      msk = scat(7'h7F, m_sel);
      if ($urandom_range(0, 3) == 0) pDto_i = 14'($urandom);
      else                           pDto_i = scat(m_word, m_sel) | (14'($urandom) & ~msk);
      @(posedge pClk_i);
      model_step();
      @(negedge pClk_i);
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
